// File: rtl/rom_icache_pkg.sv
// Shared rv32i cache package: default instruction-cache geometry, the
// miss/refill FSM state encoding, and the cache maintenance op type.
package rom_icache_pkg;

  localparam int ICACHE_ADDR_W     = 32;
  localparam int ICACHE_INDEX_W    = 6;
  localparam int ICACHE_WORD_ADR_W = 2;
  localparam int ICACHE_WAYS       = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2,
    RESP     = 2'd3
  } icache_state_e;

  typedef enum logic [1:0] {
    CACHE_OP_NONE      = 2'd0,
    CACHE_OP_INVAL_ALL = 2'd1
  } cache_op_e;

endpackage

// File: rtl/rom_icache_way.sv
// One way of the instruction cache: per-set valid flops, tag array, line
// data array and the tag compare for the lookup address.
// Ports:
//   clk, rst_n           clock, async active-low reset (valid bits only)
//   clr_all_i            invalidate every set
//   rd_index_i/word/tag  lookup address fields
//   hit_o, valid_o       lookup set valid and tag match / set valid
//   rd_data_o            word at the lookup index/word
//   wr_en_i ...          refill beat write (index, word, data)
//   fill_i, fill_tag_i   mark wr_index_i valid with the given tag
module icache_way
  import rom_icache_pkg::*;
#(
  parameter int INDEX_W    = ICACHE_INDEX_W,
  parameter int WORD_ADR_W = ICACHE_WORD_ADR_W,
  parameter int TAG_W      = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_all_i,
  input  logic [INDEX_W-1:0]    rd_index_i,
  input  logic [WORD_ADR_W-1:0] rd_word_i,
  input  logic [TAG_W-1:0]      rd_tag_i,
  output logic                  hit_o,
  output logic                  valid_o,
  output logic [31:0]           rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_W-1:0]    wr_index_i,
  input  logic [WORD_ADR_W-1:0] wr_word_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  fill_i,
  input  logic [TAG_W-1:0]      fill_tag_i
);

  localparam int SETS  = 2 ** INDEX_W;
  localparam int WORDS = SETS * (2 ** WORD_ADR_W);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [WORDS];

  assign valid_o   = valid_q[rd_index_i];
  assign hit_o     = valid_o & (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[{rd_index_i, rd_word_i}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[{wr_index_i, wr_word_i}] <= wr_data_i;
    if (fill_i)  tag_q[wr_index_i] <= fill_tag_i;
  end

endmodule

// File: rtl/rom_icache.sv
// N-way (1 or 2) set-associative instruction cache between the fetch stage
// and the ROM/SDRAM bridge. One-cycle hits, burst line refill, per-set LRU,
// whole-cache flush.
// Ports:
//   req_valid/req_addr/req_ready   fetch request handshake
//   resp_valid/resp_data           one-cycle response pulse
//   flush                          invalidate all lines (fence.i)
//   mem_req_valid/addr/ready       line refill request
//   mem_rdata_valid/mem_rdata      refill beats, ascending word order
//   busy                           FSM active or flush pending
module rom_icache
  import rom_icache_pkg::*;
#(
  parameter int ADDR_W     = ICACHE_ADDR_W,
  parameter int INDEX_W    = ICACHE_INDEX_W,
  parameter int WORD_ADR_W = ICACHE_WORD_ADR_W,
  parameter int WAYS       = ICACHE_WAYS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rdata_valid,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int OFF_W      = 2 + WORD_ADR_W;
  localparam int TAG_W      = ADDR_W - OFF_W - INDEX_W;
  localparam int LINE_WORDS = 2 ** WORD_ADR_W;

  icache_state_e         state_q, state_d;
  logic [WORD_ADR_W-1:0] cnt_q, cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  hit_vld_q, hit_vld_d;
  logic [31:0]           hit_data_q, hit_data_c;
  logic [ADDR_W-1:0]     addr_q;
  logic                  victim_q, victim_c;
  logic [31:0]           line_buf_q [LINE_WORDS];

  logic [TAG_W-1:0]      req_tag, miss_tag;
  logic [INDEX_W-1:0]    req_idx, miss_idx;
  logic [WORD_ADR_W-1:0] req_word, miss_word;

  logic [WAYS-1:0]       hit_vec, way_valid;
  logic [31:0]           way_rdata [WAYS];

  logic in_idle, flush_do, accept, hit_any, beat, last_beat;
  logic unused_bits;

  assign req_tag   = req_addr[ADDR_W-1:OFF_W+INDEX_W];
  assign req_idx   = req_addr[OFF_W+INDEX_W-1:OFF_W];
  assign req_word  = req_addr[OFF_W-1:2];
  assign miss_tag  = addr_q[ADDR_W-1:OFF_W+INDEX_W];
  assign miss_idx  = addr_q[OFF_W+INDEX_W-1:OFF_W];
  assign miss_word = addr_q[OFF_W-1:2];
  assign unused_bits = ^{req_addr[1:0], addr_q[1:0], way_valid};

  assign in_idle   = (state_q == IDLE);
  // A pending flush is applied on the first IDLE cycle and blocks requests.
  assign flush_do  = in_idle & (flush | flush_pend_q);
  assign req_ready = in_idle & ~flush & ~flush_pend_q;
  assign accept    = req_valid & req_ready;
  assign hit_any   = |hit_vec;
  assign beat      = (state_q == REFILL) & mem_rdata_valid;
  assign last_beat = beat & (cnt_q == '1);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .INDEX_W    (INDEX_W),
      .WORD_ADR_W (WORD_ADR_W),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_all_i  (flush_do),
      .rd_index_i (req_idx),
      .rd_word_i  (req_word),
      .rd_tag_i   (req_tag),
      .hit_o      (hit_vec[w]),
      .valid_o    (way_valid[w]),
      .rd_data_o  (way_rdata[w]),
      .wr_en_i    (beat & (victim_q == 1'(w))),
      .wr_index_i (miss_idx),
      .wr_word_i  (cnt_q),
      .wr_data_i  (mem_rdata),
      .fill_i     (last_beat & (victim_q == 1'(w))),
      .fill_tag_i (miss_tag)
    );
  end

  if (WAYS == 2) begin : g_lru
    // One bit per set naming the least recently used way.
    logic [2**INDEX_W-1:0] lru_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lru_q <= '0;
      end else if (last_beat) begin
        lru_q[miss_idx] <= ~victim_q;
      end else if (accept & hit_any) begin
        lru_q[req_idx] <= ~hit_vec[1];
      end
    end

    // First invalid way (way 0 preferred), else the LRU way.
    assign victim_c = ~way_valid[0] ? 1'b0 :
                      ~way_valid[1] ? 1'b1 : lru_q[req_idx];
  end else begin : g_no_lru
    assign victim_c = 1'b0;
  end

  always_comb begin
    hit_data_c = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_vec[i]) hit_data_c = way_rdata[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:     if (accept & ~hit_any) state_d = MISS_REQ;
      MISS_REQ: if (mem_req_ready) begin
                  state_d = REFILL;
                  cnt_d   = '0;
                end
      REFILL:   if (beat) begin
                  cnt_d = cnt_q + 1'b1;
                  if (last_beat) state_d = RESP;
                end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign flush_pend_d = in_idle ? 1'b0 : (flush_pend_q | flush);
  assign hit_vld_d    = accept & hit_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      hit_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      hit_vld_q    <= hit_vld_d;
    end
  end

  // Line buffer keeps the refilled line so RESP can return the requested
  // word regardless of what happens to the way arrays.
  always_ff @(posedge clk) begin
    hit_data_q <= hit_data_c;
    if (accept & ~hit_any) begin
      addr_q   <= req_addr;
      victim_q <= victim_c;
    end
    if (beat) line_buf_q[cnt_q] <= mem_rdata;
  end

  assign mem_req_valid = (state_q == MISS_REQ);
  assign mem_req_addr  = mem_req_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign resp_valid    = hit_vld_q | (state_q == RESP);
  assign resp_data     = (state_q == RESP) ? line_buf_q[miss_word] :
                         (hit_vld_q ? hit_data_q : '0);
  assign busy          = ~in_idle | flush_pend_q;

endmodule

// File: tb/tb_rom_icache.sv
module tb_rom_icache;

  localparam int LINE_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] addr;
    bit          hit;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  rom_icache #(
    .ADDR_W     (32),
    .INDEX_W    (6),
    .WORD_ADR_W (2),
    .WAYS       (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .flush           (flush),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .busy            (busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0b, want %0b", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at a drive point (1 time unit after a rising edge).
  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int flush_beat);
    logic [31:0] line;
    line      = {a[31:4], 4'h0};
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    chk_bit($sformatf("req_ready @%h", a), req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    @(negedge clk);
    if (exp_hit) begin
      chk_bit($sformatf("hit resp_valid @%h", a), resp_valid, 1'b1);
      chk_word($sformatf("hit resp_data @%h", a), resp_data, mem_word(a));
      chk_bit($sformatf("hit no mem_req @%h", a), mem_req_valid, 1'b0);
      step();
    end else begin
      chk_bit($sformatf("miss resp_valid low @%h", a), resp_valid, 1'b0);
      chk_bit($sformatf("mem_req_valid @%h", a), mem_req_valid, 1'b1);
      chk_word($sformatf("mem_req_addr @%h", a), mem_req_addr, line);
      chk_bit($sformatf("req_ready low in miss @%h", a), req_ready, 1'b0);
      step();
      @(negedge clk);
      chk_bit($sformatf("mem_req_valid held @%h", a), mem_req_valid, 1'b1);
      chk_word($sformatf("mem_req_addr held @%h", a), mem_req_addr, line);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = mem_word(line + 32'(4 * i));
        flush           = (i == flush_beat);
        @(negedge clk);
        chk_bit($sformatf("no resp during refill @%h", a), resp_valid, 1'b0);
        step();
      end
      mem_rdata_valid = 1'b0;
      mem_rdata       = '0;
      flush           = 1'b0;
      @(negedge clk);
      chk_bit($sformatf("miss resp_valid @%h", a), resp_valid, 1'b1);
      chk_word($sformatf("miss resp_data @%h", a), resp_data, mem_word(a));
      chk_bit($sformatf("busy in RESP @%h", a), busy, 1'b1);
      step();
      @(negedge clk);
      chk_bit($sformatf("resp pulse ends @%h", a), resp_valid, 1'b0);
      if (flush_beat >= 0) begin
        chk_bit($sformatf("busy flush pending @%h", a), busy, 1'b1);
        chk_bit($sformatf("req_ready flush pending @%h", a), req_ready, 1'b0);
        step();
        @(negedge clk);
      end
      chk_bit($sformatf("busy after miss @%h", a), busy, 1'b0);
      chk_bit($sformatf("req_ready after miss @%h", a), req_ready, 1'b1);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_addr        = '0;
    flush           = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;

    // Sets: 0x0000/0x1000/0x2000 -> set 0, 0x100 -> set 16, 0x3F0 -> set 63.
    tbl[0]  = '{32'h0000_0100, 1'b0};
    tbl[1]  = '{32'h0000_010C, 1'b1};
    tbl[2]  = '{32'h0000_0000, 1'b0};
    tbl[3]  = '{32'h0000_1000, 1'b0};
    tbl[4]  = '{32'h0000_0000, 1'b1};
    tbl[5]  = '{32'h0000_2000, 1'b0};
    tbl[6]  = '{32'h0000_0008, 1'b1};
    tbl[7]  = '{32'h0000_2004, 1'b1};
    tbl[8]  = '{32'h0000_1000, 1'b0};
    tbl[9]  = '{32'h0000_2000, 1'b1};
    tbl[10] = '{32'h0000_0000, 1'b0};
    tbl[11] = '{32'h0000_0104, 1'b1};
    tbl[12] = '{32'h0000_03F0, 1'b0};
    tbl[13] = '{32'hFFFF_FFFC, 1'b0};
    tbl[14] = '{32'h0000_03F4, 1'b1};
    tbl[15] = '{32'hFFFF_FFF0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset req_ready", req_ready, 1'b1);
    chk_bit("reset resp_valid", resp_valid, 1'b0);
    chk_word("reset resp_data", resp_data, 32'h0);
    chk_bit("reset mem_req_valid", mem_req_valid, 1'b0);
    chk_word("reset mem_req_addr", mem_req_addr, 32'h0);
    chk_bit("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      fetch(tbl[i].addr, tbl[i].hit, -1);
    end

    // Back-to-back hits, one per cycle.
    req_valid = 1'b1;
    req_addr  = 32'h100;
    @(negedge clk);
    chk_bit("stream ready 0", req_ready, 1'b1);
    step();
    req_addr = 32'h104;
    @(negedge clk);
    chk_bit("stream resp_valid 0", resp_valid, 1'b1);
    chk_word("stream resp_data 0", resp_data, mem_word(32'h100));
    chk_bit("stream ready 1", req_ready, 1'b1);
    step();
    req_addr = 32'h108;
    @(negedge clk);
    chk_bit("stream resp_valid 1", resp_valid, 1'b1);
    chk_word("stream resp_data 1", resp_data, mem_word(32'h104));
    chk_bit("stream ready 2", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    @(negedge clk);
    chk_bit("stream resp_valid 2", resp_valid, 1'b1);
    chk_word("stream resp_data 2", resp_data, mem_word(32'h108));
    step();
    @(negedge clk);
    chk_bit("stream resp ends", resp_valid, 1'b0);
    step();

    // Flush in IDLE beats a simultaneous request.
    req_valid = 1'b1;
    req_addr  = 32'h104;
    flush     = 1'b1;
    @(negedge clk);
    chk_bit("flush blocks req_ready", req_ready, 1'b0);
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    @(negedge clk);
    chk_bit("flushed request not answered", resp_valid, 1'b0);
    step();
    fetch(32'h100, 1'b0, -1);
    fetch(32'h0000, 1'b0, -1);

    // Flush during refill: response delivered, then everything invalid.
    fetch(32'h204, 1'b0, 1);
    fetch(32'h204, 1'b0, -1);
    fetch(32'h108, 1'b0, -1);

    // Reset in the middle of a refill.
    req_valid = 1'b1;
    req_addr  = 32'h300;
    @(negedge clk);
    chk_bit("rst seq req_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    @(negedge clk);
    chk_bit("rst seq mem_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = mem_word(32'h300 + 32'(4 * i));
      step();
    end
    mem_rdata_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_bit("mid-refill reset req_ready", req_ready, 1'b1);
    chk_bit("mid-refill reset resp_valid", resp_valid, 1'b0);
    chk_word("mid-refill reset resp_data", resp_data, 32'h0);
    chk_bit("mid-refill reset mem_req_valid", mem_req_valid, 1'b0);
    chk_word("mid-refill reset mem_req_addr", mem_req_addr, 32'h0);
    chk_bit("mid-refill reset busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      chk_bit("stray beat resp_valid", resp_valid, 1'b0);
      chk_bit("stray beat busy", busy, 1'b0);
      chk_bit("stray beat mem_req_valid", mem_req_valid, 1'b0);
      step();
    end
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    fetch(32'h300, 1'b0, -1);
    fetch(32'h104, 1'b0, -1);
    fetch(32'h30C, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/rom_icache.md
# rom_icache

Parametrised, N-way set-associative instruction cache between the rv32i fetch stage and the ROM/SDRAM bridge. Adds over the current ROM cache:
- configurable geometry;
- its own miss/refill state machine with a valid/ready burst interface to memory;
- per-set LRU replacement;
- a whole-cache flush for `fence.i`.

Hits return in one cycle at full throughput.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `INDEX_W`, 6, set-index bits (sets = 2**INDEX_W)
- `WORD_ADR_W`, 2, word-in-line bits (line = 2**WORD_ADR_W words)
- `WAYS`, 2, associativity, legal values 1 or 2

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  fetch request
- `req_addr`  in  ADDR_W  byte address; bits [1:0] ignored
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `resp_valid`  out  1  one-cycle pulse; no backpressure
- `resp_data`  out  32  instruction word
- `flush`  in  1  invalidate every line
- `mem_req_valid`  out  1  line-refill request
- `mem_req_addr`  out  ADDR_W  line-aligned address (low 2+WORD_ADR_W bits zero)
- `mem_req_ready`  in  1  memory accepts request
- `mem_rdata_valid`  in  1  one beat of refill data
- `mem_rdata`  in  32  refill word, beats in ascending word order
- `busy`  out  1  FSM not in IDLE, or flush pending

## Operation
- Address split:
  - tag = `req_addr[ADDR_W-1 : 2+WORD_ADR_W+INDEX_W]`
  - index = next INDEX_W bits
  - word = `req_addr[2+WORD_ADR_W-1:2]`
- Storage per way: valid flop per set, tag and line data per set.
- FSM states: IDLE, MISS_REQ, REFILL, RESP.
- IDLE:
  - `req_ready = ~flush`.
  - On accept, all ways are compared in the same cycle.
  - Hit: `resp_valid`/`resp_data` registered for the next cycle; LRU for that set points to the other way.
  - Miss: latch address, go to MISS_REQ.
- MISS_REQ:
  - `mem_req_valid=1`, holding the line address until `mem_req_ready`; then go to REFILL with the beat counter at 0.
- REFILL:
  - Each `mem_rdata_valid` writes `mem_rdata` into the victim way at the counter position, then increments the counter.
  - On the last beat (counter = 2**WORD_ADR_W-1): set valid, write the tag, set LRU to the other way, go to RESP.
  - Beats seen outside REFILL are ignored.
- RESP:
  - `resp_valid=1` for one cycle with the requested word, taken from the line buffer; then go to IDLE.
  - `req_ready=0`.
- Victim selection: the first invalid way, with way 0 preferred; otherwise the LRU way. When WAYS=1, the victim is always way 0 and there is no LRU state.
- Flush:
  - In IDLE: clears all valid bits in one cycle and takes priority over a simultaneous `req_valid`, which is not accepted.
  - In any other state: latched as pending and applied on the cycle the FSM returns to IDLE. The line just refilled is invalidated, but its response is still delivered.
  - While pending, `req_ready=0`.
- Reset (asynchronous, any state, including mid-refill):
  - FSM returns to IDLE; valid bits, LRU, beat counter and pending flush are cleared.
  - `req_ready=1`; all other outputs are 0.
  - Data and tag arrays need no reset.

## Timing
- Hit latency: `resp_valid` one cycle after the accept cycle.
- Back-to-back hits: one per cycle.
- Miss:
  - `mem_req_valid` rises the cycle after accept.
  - `resp_valid` comes the cycle after the last beat is sampled.
  - The next request can be accepted the cycle after `resp_valid`.
- A hit response in cycle N+1 may coincide with acceptance of a new request in N+1.
- A miss accepted in N drops `req_ready` from N+1.
- `mem_req_addr` is stable while `mem_req_valid=1`.

## Structure
- Shared rv32i package:
  - `icache_state_e` (IDLE, MISS_REQ, REFILL, RESP);
  - default geometry localparams;
  - `cache_op_e` stays as is.
- Tag width is derived locally from the parameters, not from a package typedef.
- Sub-module `icache_way` holds valid/tag/data storage for one way and its hit compare; it is instantiated WAYS times by generate.
- The FSM, LRU bits and line buffer live in the top module.

## Test plan
- Reset, then fetch 0x100 (WAYS=2, WORD_ADR_W=2) → `mem_req_addr=0x100`; 4 beats A0..A3 → `resp_data=A0` one cycle after the 4th beat; refetch 0x10C → hit, `A3` one cycle later.
- Stream hits 0x100, 0x104, 0x108 on consecutive cycles → three consecutive `resp_valid` pulses, with `req_ready` high throughout.
- Fill 0x0000, 0x1000 (same set), touch 0x0000, then miss 0x2000 → the way holding 0x1000 is replaced; 0x0000 still hits and 0x1000 misses.
- Assert `flush` with `req_valid` in IDLE → request not accepted, all lines invalid; the next fetch of 0x100 misses.
- Assert `flush` during REFILL → response still delivered; `busy` stays high one extra cycle; the refilled line misses afterwards.
- Drop `rst_n` mid-REFILL after 2 beats → outputs 0 and `req_ready=1` immediately; the old address misses and stray beats are ignored.
